// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite initiator: response codes and FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: one local command in, one AXI-Lite transaction out, one response back.
// Every AXI output comes straight from a flop; next values are decoded from the next state
// so VALID/READY change on the clock edge after the event that caused them.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  A_CLK,
    input  logic                  A_RESET_n,
    // local command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    // local response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AXI-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] AW_ADDR,
    output logic                  AW_VALID,
    input  logic                  AW_READY,
    output logic [DATA_WIDTH-1:0] W_DATA,
    output logic [STRB_WIDTH-1:0] W_STRB,
    output logic                  W_VALID,
    input  logic                  W_READY,
    input  logic [1:0]            B_RESP,
    input  logic                  B_VALID,
    output logic                  B_READY,
    // AXI-Lite read address / data
    output logic [ADDR_WIDTH-1:0] AR_ADDR,
    output logic                  AR_VALID,
    input  logic                  AR_READY,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    input  logic [1:0]            R_RESP,
    input  logic                  R_VALID,
    output logic                  R_READY
);

    // Word-align every outgoing address.
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t                state_reg, state_next;
    logic                  aw_done_reg, aw_done_next;
    logic                  w_done_reg, w_done_next;
    logic                  cmd_ready_reg, cmd_ready_next;
    logic                  aw_valid_reg, aw_valid_next;
    logic                  w_valid_reg, w_valid_next;
    logic                  b_ready_reg, b_ready_next;
    logic                  ar_valid_reg, ar_valid_next;
    logic                  r_ready_reg, r_ready_next;
    logic                  rsp_valid_reg, rsp_valid_next;

    logic [ADDR_WIDTH-1:0] aw_addr_reg, ar_addr_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_WIDTH-1:0] w_strb_reg;
    logic                  rsp_write_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic [1:0]            rsp_resp_reg;

    logic cmd_accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

    assign cmd_accept = cmd_valid && cmd_ready_reg;
    assign aw_hs      = aw_valid_reg && AW_READY;
    assign w_hs       = w_valid_reg && W_READY;
    assign b_hs       = b_ready_reg && B_VALID;
    assign ar_hs      = ar_valid_reg && AR_READY;
    assign r_hs       = r_ready_reg && R_VALID;
    assign rsp_hs     = rsp_valid_reg && rsp_ready;

    // Next-state, handshake tracking and decoded next values of all VALID/READY flops.
    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_accept) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_next = 1'b1;
                if (w_hs)  w_done_next  = 1'b1;
                if (aw_done_next && w_done_next) state_next = WR_RESP;
            end
            WR_RESP: if (b_hs)   state_next = RSP;
            RD_REQ:  if (ar_hs)  state_next = RD_RESP;
            RD_RESP: if (r_hs)   state_next = RSP;
            RSP:     if (rsp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        cmd_ready_next = (state_next == IDLE);
        aw_valid_next  = (state_next == WR_REQ) && !aw_done_next;
        w_valid_next   = (state_next == WR_REQ) && !w_done_next;
        b_ready_next   = (state_next == WR_RESP);
        ar_valid_next  = (state_next == RD_REQ);
        r_ready_next   = (state_next == RD_RESP);
        rsp_valid_next = (state_next == RSP);
    end

    // Control flops: state, handshake flags and all registered VALID/READY outputs.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            state_reg     <= IDLE;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            cmd_ready_reg <= 1'b1;
            aw_valid_reg  <= 1'b0;
            w_valid_reg   <= 1'b0;
            b_ready_reg   <= 1'b0;
            ar_valid_reg  <= 1'b0;
            r_ready_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            cmd_ready_reg <= cmd_ready_next;
            aw_valid_reg  <= aw_valid_next;
            w_valid_reg   <= w_valid_next;
            b_ready_reg   <= b_ready_next;
            ar_valid_reg  <= ar_valid_next;
            r_ready_reg   <= r_ready_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    // Datapath: latch the command on acceptance and hold the response until it is consumed.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            aw_addr_reg   <= '0;
            ar_addr_reg   <= '0;
            w_data_reg    <= '0;
            w_strb_reg    <= '0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= RESP_OKAY;
        end else begin
            if (cmd_accept) begin
                if (cmd_write) begin
                    aw_addr_reg <= cmd_addr & WORD_MASK;
                    w_data_reg  <= cmd_wdata;
                    w_strb_reg  <= cmd_wstrb;
                end else begin
                    ar_addr_reg <= cmd_addr & WORD_MASK;
                end
            end
            if (b_hs) begin
                rsp_write_reg <= 1'b1;
                rsp_rdata_reg <= '0;
                rsp_resp_reg  <= B_RESP;
            end else if (r_hs) begin
                rsp_write_reg <= 1'b0;
                rsp_rdata_reg <= R_DATA;
                rsp_resp_reg  <= R_RESP;
            end
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_write = rsp_write_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;
    assign AW_ADDR   = aw_addr_reg;
    assign AW_VALID  = aw_valid_reg;
    assign W_DATA    = w_data_reg;
    assign W_STRB    = w_strb_reg;
    assign W_VALID   = w_valid_reg;
    assign B_READY   = b_ready_reg;
    assign AR_ADDR   = ar_addr_reg;
    assign AR_VALID  = ar_valid_reg;
    assign R_READY   = r_ready_reg;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master driving a behavioural 4-register AXI-Lite slave
// (0x00..0x0C OKAY, anything else SLVERR / 0xDEADFEED) with per-channel READY delays.
module tb_axi_lite_master;

    logic        A_CLK;
    logic        A_RESET_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AW_ADDR, W_DATA, AR_ADDR, R_DATA;
    logic [3:0]  W_STRB;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [1:0]  B_RESP, R_RESP;

    int tests = 0;
    int fails = 0;

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .A_CLK(A_CLK), .A_RESET_n(A_RESET_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
    );

    initial A_CLK = 1'b0;
    always #5 A_CLK = ~A_CLK;

    // ---------------- behavioural slave ----------------
    int aw_dly = 1, w_dly = 1, ar_dly = 1;
    int aw_cnt, w_cnt, ar_cnt;
    logic [31:0] regs [4];
    logic        aw_got, w_got;
    logic [31:0] aw_addr_s, w_data_s;
    logic [3:0]  w_strb_s;
    logic        aw_hs_s, w_hs_s;
    logic [31:0] s_waddr, s_wdata;
    logic [3:0]  s_wstrb;

    assign AW_READY = AW_VALID && (aw_cnt >= aw_dly);
    assign W_READY  = W_VALID && (w_cnt >= w_dly);
    assign AR_READY = AR_VALID && (ar_cnt >= ar_dly);
    assign aw_hs_s  = AW_VALID && AW_READY;
    assign w_hs_s   = W_VALID && W_READY;
    assign s_waddr  = aw_hs_s ? AW_ADDR : aw_addr_s;
    assign s_wdata  = w_hs_s ? W_DATA : w_data_s;
    assign s_wstrb  = w_hs_s ? W_STRB : w_strb_s;

    // Slave: READY after a programmable wait, write once both AW and W have arrived, answer next cycle.
    always @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
            B_VALID <= 1'b0; B_RESP <= 2'b00;
            R_VALID <= 1'b0; R_RESP <= 2'b00; R_DATA <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            aw_cnt <= (AW_VALID && !AW_READY) ? aw_cnt + 1 : 0;
            w_cnt  <= (W_VALID && !W_READY) ? w_cnt + 1 : 0;
            ar_cnt <= (AR_VALID && !AR_READY) ? ar_cnt + 1 : 0;
            if (B_VALID && B_READY) B_VALID <= 1'b0;
            if (R_VALID && R_READY) R_VALID <= 1'b0;
            if (aw_hs_s) begin aw_got <= 1'b1; aw_addr_s <= AW_ADDR; end
            if (w_hs_s) begin w_got <= 1'b1; w_data_s <= W_DATA; w_strb_s <= W_STRB; end
            if ((aw_got || aw_hs_s) && (w_got || w_hs_s)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                B_VALID <= 1'b1;
                if (s_waddr[31:4] == 28'd0) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) regs[s_waddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                    B_RESP <= 2'b00;
                end else begin
                    B_RESP <= 2'b10;
                end
            end
            if (AR_VALID && AR_READY) begin
                R_VALID <= 1'b1;
                if (AR_ADDR[31:4] == 28'd0) begin
                    R_DATA <= regs[AR_ADDR[3:2]];
                    R_RESP <= 2'b00;
                end else begin
                    R_DATA <= 32'hDEADFEED;
                    R_RESP <= 2'b10;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a command and return at the negedge of the first cycle after acceptance.
    task automatic send_cmd(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge A_CLK);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(negedge A_CLK); n++; end
        check({tag, "_accept"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge A_CLK);
        @(negedge A_CLK);
        cmd_valid = 1'b0;
        $display("[TB] cmd %s write=%0d addr=0x%08h data=0x%08h strb=0x%h", tag, w, a, d, s);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 50) begin @(negedge A_CLK); n++; end
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic take_rsp(output logic w, output logic [31:0] rd, output logic [1:0] rs);
        w = rsp_write; rd = rsp_rdata; rs = rsp_resp;
        rsp_ready = 1'b1;
        @(negedge A_CLK);
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd, input logic [1:0] exp_rs);
        logic        gw;
        logic [31:0] grd;
        logic [1:0]  grs;
        send_cmd(tag, w, a, d, s);
        wait_rsp(tag);
        take_rsp(gw, grd, grs);
        check({tag, "_rsp_write"}, {31'd0, gw}, {31'd0, w});
        check({tag, "_rsp_rdata"}, grd, exp_rd);
        check({tag, "_rsp_resp"}, {30'd0, grs}, {30'd0, exp_rs});
        $display("[TB] rsp %s write=%0d rdata=0x%08h resp=%0b", tag, gw, grd, grs);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic        gw;
        logic [31:0] grd;
        logic [1:0]  grs;

        A_RESET_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge A_CLK);
        A_RESET_n = 1'b1;
        @(negedge A_CLK);

        // Reset state
        check("rst_ctrl", {25'd0, cmd_ready, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid},
              32'h40);
        check("rst_aw_addr", AW_ADDR, 32'h0);
        check("rst_ar_addr", AR_ADDR, 32'h0);
        check("rst_w_data", W_DATA, 32'h0);
        check("rst_w_strb", {28'd0, W_STRB}, 32'h0);
        check("rst_rsp", {rsp_rdata[28:0], rsp_write, rsp_resp}, 32'h0);

        // Write with unaligned address: VALIDs in first cycle, address aligned
        send_cmd("wr04", 1'b1, 32'h0000_0007, 32'hA5A5_0001, 4'hF);
        check("wr04_valids", {29'd0, AW_VALID, W_VALID, cmd_ready}, 32'h6);
        check("wr04_aw_addr", AW_ADDR, 32'h0000_0004);
        check("wr04_w_data", W_DATA, 32'hA5A5_0001);
        check("wr04_w_strb", {28'd0, W_STRB}, 32'hF);
        wait_rsp("wr04");
        take_rsp(gw, grd, grs);
        check("wr04_rsp_write", {31'd0, gw}, 32'd1);
        check("wr04_rsp_rdata", grd, 32'h0);
        check("wr04_rsp_resp", {30'd0, grs}, 32'h0);
        $display("[TB] rsp wr04 write=%0d rdata=0x%08h resp=%0b", gw, grd, grs);

        // Read with an always-ready slave: rsp_valid first seen in cycle N+3
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        send_cmd("rd04", 1'b0, 32'h0000_0004, 32'h0, 4'h0);
        check("rd04_ar_valid_n1", {31'd0, AR_VALID}, 32'd1);
        check("rd04_ar_addr", AR_ADDR, 32'h0000_0004);
        check("rd04_rsp_n1", {31'd0, rsp_valid}, 32'd0);
        @(negedge A_CLK);
        check("rd04_rsp_n2", {31'd0, rsp_valid}, 32'd0);
        @(negedge A_CLK);
        check("rd04_rsp_n3", {31'd0, rsp_valid}, 32'd1);
        take_rsp(gw, grd, grs);
        check("rd04_rsp_write", {31'd0, gw}, 32'd0);
        check("rd04_rsp_rdata", grd, 32'hA5A5_0001);
        check("rd04_rsp_resp", {30'd0, grs}, 32'h0);
        $display("[TB] rsp rd04 write=%0d rdata=0x%08h resp=%0b", gw, grd, grs);
        aw_dly = 1; w_dly = 1; ar_dly = 1;

        // Byte strobes
        txn("wr08a", 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00);
        txn("wr08b", 1'b1, 32'h08, 32'h0000_1234, 4'h3, 32'h0, 2'b00);
        txn("rd08",  1'b0, 32'h08, 32'h0, 4'h0, 32'hFFFF_1234, 2'b00);

        // Out-of-range address: SLVERR both ways
        txn("wr40", 1'b1, 32'h40, 32'h1357_9BDF, 4'hF, 32'h0, 2'b10);
        txn("rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_FEED, 2'b10);

        // Response back-pressure: everything holds, then cmd_ready returns next cycle
        send_cmd("hold", 1'b0, 32'h08, 32'h0, 4'h0);
        wait_rsp("hold");
        for (int i = 0; i < 10; i++) begin
            @(negedge A_CLK);
            check("hold_ctrl", {27'd0, cmd_ready, AW_VALID, W_VALID, AR_VALID, rsp_valid}, 32'h1);
            check("hold_rdata", rsp_rdata, 32'hFFFF_1234);
            check("hold_resp", {29'd0, rsp_write, rsp_resp}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge A_CLK);
        rsp_ready = 1'b0;
        check("hold_release", {30'd0, cmd_ready, rsp_valid}, 32'h2);
        $display("[TB] rsp hold released");

        // AW_READY 3 cycles late, W_READY immediate: per-cycle {AW_VALID, W_VALID, B_READY}
        aw_dly = 3; w_dly = 0;
        send_cmd("stub", 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF);
        check("stub_c1", {29'd0, AW_VALID, W_VALID, B_READY}, 32'h6);
        @(negedge A_CLK);
        check("stub_c2", {29'd0, AW_VALID, W_VALID, B_READY}, 32'h4);
        @(negedge A_CLK);
        check("stub_c3", {29'd0, AW_VALID, W_VALID, B_READY}, 32'h4);
        @(negedge A_CLK);
        check("stub_c4", {29'd0, AW_VALID, W_VALID, B_READY}, 32'h4);
        @(negedge A_CLK);
        check("stub_c5", {29'd0, AW_VALID, W_VALID, B_READY}, 32'h1);
        wait_rsp("stub");
        take_rsp(gw, grd, grs);
        check("stub_rsp", {29'd0, gw, grs}, 32'h4);
        $display("[TB] rsp stub write=%0d resp=%0b", gw, grs);
        aw_dly = 1; w_dly = 1;
        txn("rd0c", 1'b0, 32'h0C, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00);

        // Reset while W_VALID is up: outputs clear before the next edge, no response
        send_cmd("rstw", 1'b1, 32'h00, 32'h1111_1111, 4'hF);
        check("rstw_w_valid", {31'd0, W_VALID}, 32'd1);
        #1 A_RESET_n = 1'b0;
        #1;
        check("rstw_clear", {25'd0, AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, rsp_valid, cmd_ready},
              32'h1);
        @(negedge A_CLK);
        check("rstw_hold_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge A_CLK);
        A_RESET_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge A_CLK);
            check("rstw_after", {30'd0, cmd_ready, rsp_valid}, 32'h2);
        end
        $display("[TB] reset mid-write applied and released");
        txn("rd00", 1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00);
        txn("rd0c_rst", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI-Lite initiator that turns single-beat register commands from local logic into AXI-Lite write or read transactions and returns the response. It is the counterpart of the 4-register AXI-Lite slave: its AXI ports connect one-to-one to that slave's ports. It handles one transaction at a time with no outstanding-transaction overlap, and provides a simple valid/ready command port and response port toward the local side.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; STRB_WIDTH = DATA_WIDTH/8

- A_CLK  in  1  single clock, all logic rising-edge
- A_RESET_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  STRB_WIDTH  write byte enables
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_write  out  1  echoes cmd_write of the completed transaction
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  B_RESP or R_RESP as received
- AW_ADDR/AW_VALID out, AW_READY in; W_DATA/W_STRB/W_VALID out, W_READY in; B_RESP/B_VALID in, B_READY out; AR_ADDR/AR_VALID out, AR_READY in; R_DATA/R_RESP/R_VALID in, R_READY out. Widths follow the AXI-Lite channel definitions.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On acceptance, register addr/data/strb/write. Go to WR_REQ or RD_REQ.
- Addresses: AW_ADDR/AR_ADDR = cmd_addr with bits [1:0] forced to 0.
- WR_REQ: AW_VALID and W_VALID are asserted together. Each drops independently in the cycle after its own handshake; a VALID is never dropped before its handshake. Two flags, aw_done and w_done, track the handshakes. When both are done, with either order or the same cycle, go to WR_RESP.
- WR_RESP: B_READY=1. On B_VALID, capture B_RESP, set rsp_rdata=0, go to RSP.
- RD_REQ: AR_VALID=1 until handshake, then RD_RESP.
- RD_RESP: R_READY=1. On R_VALID, capture R_DATA/R_RESP, go to RSP.
- RSP: rsp_valid=1 and rsp fields stable until rsp_ready, then IDLE. A new command is accepted only in IDLE, so there is no back-to-back command/response overlap.
- B_READY and R_READY are high only in their respective response states.
- All AXI outputs are registered and do not depend combinationally on AXI inputs.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): state=IDLE. All VALID/READY outputs 0 except cmd_ready=1. AW_ADDR, AR_ADDR, W_DATA, W_STRB, rsp_rdata, rsp_resp and rsp_write are 0.
- Command accepted at edge N: AXI VALID is high in cycle N+1.
- With an always-ready slave and an immediate response, rsp_valid is high in cycle N+3. The 4-register slave adds one cycle of READY latency per request channel.
- Reset mid-transaction: outputs clear immediately and the transaction is abandoned with no response. The bench must reset the slave together with the master.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RSP.

## Structure
- Package axi_lite_pkg: response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus the state encoding for this block.
- No sub-module. The response holding register lives inside the module.

## Test plan
- Write 0x04 data 0xA5A50001 strb 0xF, then read 0x04 -> write rsp_resp 00; read rsp_rdata 0xA5A50001, rsp_resp 00.
- Write 0x08 data 0xFFFFFFFF strb 0xF, then write 0x08 data 0x00001234 strb 0x3, then read 0x08 -> rsp_rdata 0xFFFF1234.
- Write 0x40 -> rsp_resp 10. Read 0x40 -> rsp_rdata 0xDEADFEED, rsp_resp 10.
- Hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp fields stable, cmd_ready=0, all AXI VALIDs 0. Assert rsp_ready -> cmd_ready=1 next cycle.
- Against a stub slave with AW_READY delayed 3 cycles and W_READY 0 cycles -> W_VALID drops after 1 cycle, AW_VALID held 4 cycles, and B_READY rises only after both handshakes.
- Assert A_RESET_n=0 while W_VALID=1 -> all VALIDs 0 before the next edge and no rsp_valid. After release, a normal read succeeds.
